fpu_add_sub_top: RTL and testbench
==================================

# fpu_add_sub_top

Single-precision IEEE-754 floating-point adder/subtractor. It is the top level of the FPU arithmetic path: it takes two binary32 operands and an add/sub select, and produces the rounded binary32 result with overflow and underflow flags. The datapath is fully combinational. An optional output register stage makes the block synchronous on one clock.

## Interface
Parameters: none.

Ports:
- i_clk  input  1  clock. Only used when the output register is compiled in.
- i_rst_n  input  1  reset, asynchronous, active-low. Only used when the output register is compiled in.
- i_32_a  input  32  operand A. Bit 31 is the sign, [30:23] the exponent, [22:0] the mantissa.
- i_32_b  input  32  operand B, same format as A.
- i_add_sub  input  1  0 computes A+B; 1 computes A−B.
- o_32_s  output  32  binary32 result.
- o_ov_flag  output  1  overflow or infinity result.
- o_un_flag  output  1  underflow; the result was flushed to zero.

## Operation
- Effective B sign is b[31] XOR i_add_sub.
- Unpacking:
  - Exponent 1–254: hidden bit 1.
  - Exponent 0 (subnormal): hidden bit 0, effective exponent 1.
- Alignment:
  - Swap operands so the larger magnitude (exponent, then mantissa) is the major operand.
  - Right-shift the minor significand by the exponent difference, keeping guard, round and sticky bits.
  - A difference ≥ 26 collapses the minor operand into sticky.
- Same effective signs: add the significands. On carry-out, shift right 1 and increment the exponent.
- Different signs: subtract minor from major. Left-normalise with a leading-zero count; the exponent decreases by the shift. The result sign is the major operand's sign.
- Rounding: round-to-nearest-even on guard/round/sticky. A mantissa carry from rounding renormalises and increments the exponent.
- Exact zero result (including x − x): +0 (0x00000000), flags 0.
- Overflow: a final exponent ≥ 255 gives o_32_s = ±infinity (sign, 0xFF, 0) and o_ov_flag = 1.
- Underflow: a nonzero result whose normalised exponent is < 1 is flushed to signed zero with o_un_flag = 1. No subnormal outputs are produced.
- Special inputs (priority order):
  1. Any NaN operand, or +inf + −inf (effective): o_32_s = 0x7FC00000, both flags 0.
  2. Exactly one infinite operand, or both infinite with the same effective sign: o_32_s = that infinity, o_ov_flag = 1.
- Zero operands: the result is the other operand, with its effective sign applied when A is zero. (+0) + (+0) = +0 and (−0) + (−0) = −0.
- The flags are mutually exclusive.

## Timing
- Without FPU_OUT_REG_EN:
  - Outputs are a pure combinational function of i_32_a, i_32_b and i_add_sub, with zero-cycle latency.
  - i_clk and i_rst_n are ignored.
- With FPU_OUT_REG_EN:
  - The combinational result and both flags are registered on the rising edge of i_clk, giving 1-cycle latency.
  - There is no handshake; a new operand pair is accepted every cycle.
  - While i_rst_n = 0 (asserted asynchronously at any time, including mid-stream): o_32_s = 0x00000000, o_ov_flag = 0, o_un_flag = 0.
  - The first valid output appears on the first rising edge after i_rst_n deasserts.

## Configuration
- FPU_OUT_REG_EN:
  - Defined: the output register stage described under Timing is instantiated.
  - Undefined: outputs are driven directly by the combinational datapath and no flops are inferred.
- Functional results are identical in both configurations apart from latency and reset value.

## Test plan
- Add: 0x41E00000 (28) + 0x40700000 (3.75), i_add_sub=0 → o_32_s = 0x41FE0000 (31.75). Likewise 0x41700000 (15) + 0x41120000 (9.125) → 0x41C10000 (24.125). Flags 0.
- Subtract: 0x3F400000 (0.75) − 0x41320000 (11.125), i_add_sub=1 → 0xC1260000 (−10.375). Likewise 0xC10E0000 (−8.875) − 0xC1CA0000 (−25.25) → 0x41830000 (16.375).
- Infinity: 0x7F800000 + 0x41320000 → 0x7F800000, o_ov_flag = 1. Also 0xC3A30000 + 0x7F800000 → 0x7F800000, o_ov_flag = 1.
- Overflow: 0x7F060000 + 0x7F600000 (both exponent 254) → 0x7F800000, o_ov_flag = 1.
- Underflow: 0x00800002 − 0x00400001, i_add_sub=1 → 0x00000000, o_un_flag = 1, o_ov_flag = 0.
- Random sweep: 100 add and 100 sub pairs of $random/1000.0 values → result within ±1 ULP of the simulator's shortreal result. With FPU_OUT_REG_EN, check 1-cycle latency and zeroed outputs during asynchronous reset.

Source files
------------

// File: rtl/fpu_add_sub_top.sv
// fpu_add_sub_top: binary32 adder/subtractor with round-to-nearest-even.
// Overflow saturates to a signed infinity, and underflow flushes to a signed zero.
// NaN inputs, and inf - inf, produce the canonical quiet NaN 0x7FC00000.
// Define FPU_OUT_REG_EN to register the result and flags on i_clk.
// The register gives one cycle of latency and is cleared asynchronously by i_rst_n.
module fpu_add_sub_top (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_32_a,
    input  logic [31:0] i_32_b,
    input  logic        i_add_sub,
    output logic [31:0] o_32_s,
    output logic        o_ov_flag,
    output logic        o_un_flag
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Leading-zero count of a 27-bit significand; 27 when the value is zero.
    function automatic logic [4:0] lead_zeros(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // Round-to-nearest-even of {sig[23:0], guard, round, sticky}.
    // Returns {carry, sig[23:0]}.
    function automatic logic [24:0] round_rne(input logic [26:0] v);
        logic up;
        up = v[2] & (v[1] | v[0] | v[3]);
        return {1'b0, v[26:3]} + {24'd0, up};
    endfunction

    // Unpacked operands. Subnormals use a hidden bit of 0 and an effective exponent of 1.
    logic              sign_a, sign_b;
    logic [7:0]        exp_a, exp_b;
    logic [23:0]       sig_a, sig_b;
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign sign_a = i_32_a[31];
    assign sign_b = i_32_b[31] ^ i_add_sub;
    assign exp_a  = (i_32_a[30:23] == 8'd0) ? 8'd1 : i_32_a[30:23];
    assign exp_b  = (i_32_b[30:23] == 8'd0) ? 8'd1 : i_32_b[30:23];
    assign sig_a  = {i_32_a[30:23] != 8'd0, i_32_a[22:0]};
    assign sig_b  = {i_32_b[30:23] != 8'd0, i_32_b[22:0]};
    assign nan_a  = (i_32_a[30:23] == 8'hFF) && (i_32_a[22:0] != 23'd0);
    assign nan_b  = (i_32_b[30:23] == 8'hFF) && (i_32_b[22:0] != 23'd0);
    assign inf_a  = (i_32_a[30:23] == 8'hFF) && (i_32_a[22:0] == 23'd0);
    assign inf_b  = (i_32_b[30:23] == 8'hFF) && (i_32_b[22:0] == 23'd0);
    assign zero_a = (i_32_a[30:0] == 31'd0);
    assign zero_b = (i_32_b[30:0] == 31'd0);

    logic              swap, sign_maj;
    logic [7:0]        exp_maj, exp_min, exp_diff;
    logic [23:0]       sig_maj, sig_min;
    logic [49:0]       shifted;
    logic [26:0]       op_maj, op_min, norm;
    logic [27:0]       raw;
    logic [4:0]        lz;
    logic signed [9:0] exp_norm, exp_final;
    logic [24:0]       rounded;
    logic [31:0]       comb_s;
    logic              comb_ov, comb_un;
    logic              unused_bits;

    // Align, add/subtract, normalise, round and select special-case results.
    always_comb begin
        swap     = {exp_b, sig_b} > {exp_a, sig_a};
        exp_maj  = swap ? exp_b  : exp_a;
        exp_min  = swap ? exp_a  : exp_b;
        sig_maj  = swap ? sig_b  : sig_a;
        sig_min  = swap ? sig_a  : sig_b;
        sign_maj = swap ? sign_b : sign_a;
        exp_diff = exp_maj - exp_min;

        // Minor significand gets 26 extra low bits.
        // The top two become guard/round; everything lower folds into sticky.
        shifted = {sig_min, 26'd0} >> exp_diff;
        if (exp_diff >= 8'd26) op_min = {26'd0, |sig_min};
        else                   op_min = {shifted[49:24], |shifted[23:0]};
        op_maj = {sig_maj, 3'b000};

        if (sign_a == sign_b) raw = {1'b0, op_maj} + {1'b0, op_min};
        else                  raw = {1'b0, op_maj} - {1'b0, op_min};

        lz       = 5'd0;
        exp_norm = signed'({2'b00, exp_maj});
        if (raw[27]) begin
            norm     = {raw[27:2], raw[1] | raw[0]};
            exp_norm = exp_norm + 10'sd1;
        end else begin
            lz       = lead_zeros(raw[26:0]);
            norm     = raw[26:0] << lz;
            exp_norm = exp_norm - signed'({5'd0, lz});
        end

        rounded   = round_rne(norm);
        exp_final = exp_norm + signed'({9'd0, rounded[24]});

        comb_ov = 1'b0;
        comb_un = 1'b0;
        if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
            comb_s = QNAN;
        end else if (inf_a) begin
            comb_s  = {sign_a, 8'hFF, 23'd0};
            comb_ov = 1'b1;
        end else if (inf_b) begin
            comb_s  = {sign_b, 8'hFF, 23'd0};
            comb_ov = 1'b1;
        end else if (zero_a && zero_b) begin
            // Mixed-sign zeros give +0; matching signs keep that sign.
            comb_s = {sign_a & sign_b, 31'd0};
        end else if (zero_a) begin
            comb_s = {sign_b, i_32_b[30:0]};
        end else if (zero_b) begin
            comb_s = i_32_a;
        end else if (raw == 28'd0) begin
            comb_s = 32'd0;
        end else if (exp_norm < 10'sd1) begin
            comb_s  = {sign_maj, 31'd0};
            comb_un = 1'b1;
        end else if (exp_final >= 10'sd255) begin
            comb_s  = {sign_maj, 8'hFF, 23'd0};
            comb_ov = 1'b1;
        end else begin
            // Hidden bit is implied; after a rounding carry the fraction is zero.
            comb_s = {sign_maj, exp_final[7:0], rounded[22:0]};
        end
    end

`ifdef FPU_OUT_REG_EN
    // Output register: capture the result each cycle, clear while reset is held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_32_s    <= 32'd0;
            o_ov_flag <= 1'b0;
            o_un_flag <= 1'b0;
        end else begin
            o_32_s    <= comb_s;
            o_ov_flag <= comb_ov;
            o_un_flag <= comb_un;
        end
    end
    assign unused_bits = rounded[23];
`else
    assign o_32_s      = comb_s;
    assign o_ov_flag   = comb_ov;
    assign o_un_flag   = comb_un;
    assign unused_bits = rounded[23] ^ i_clk ^ i_rst_n;
`endif

endmodule

// File: tb/tb_fpu_add_sub_top.sv
// Directed and sweep testbench for fpu_add_sub_top; adapts to FPU_OUT_REG_EN.
module tb_fpu_add_sub_top;
    logic        clk;
    logic        rst_n;
    logic [31:0] in_a, in_b;
    logic        add_sub;
    logic [31:0] s;
    logic        ov, un;
    int          vectors;
    int          miscompares;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] s;
        logic        ov;
        logic        un;
    } vec_t;

    fpu_add_sub_top dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_32_a    (in_a),
        .i_32_b    (in_b),
        .i_add_sub (add_sub),
        .o_32_s    (s),
        .o_ov_flag (ov),
        .o_un_flag (un)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    // Drive operands and wait until the result is observable.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic op);
        in_a = a; in_b = b; add_sub = op;
`ifdef FPU_OUT_REG_EN
        @(posedge clk); #1;
`else
        #1;
`endif
    endtask

    // Truncate a real to binary32 bits (normal range only).
    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic real f32_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
`ifdef FPU_OUT_REG_EN
        in_a = 32'h41E00000; in_b = 32'h40700000; add_sub = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (s !== 32'd0 || ov !== 1'b0 || un !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got s=%h ov=%b un=%b, expected s=00000000 ov=0 un=0", s, ov, un);
        end
        #2 rst_n = 1'b1;
        #1;
        vectors++;
        if (s !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_release_no_edge: got s=%h, expected 00000000", s);
        end
        @(posedge clk); #1;
        vectors++;
        if (s !== 32'h41FE0000 || ov !== 1'b0 || un !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_out: got s=%h ov=%b un=%b, expected s=41fe0000 ov=0 un=0", s, ov, un);
        end
`else
        apply(32'h41E00000, 32'h40700000, 1'b0);
        vectors++;
        if (s !== 32'h41FE0000 || ov !== 1'b0 || un !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ignored: got s=%h ov=%b un=%b, expected s=41fe0000 ov=0 un=0", s, ov, un);
        end
        rst_n = 1'b1;
`endif
    endtask

    task automatic test_add();
        vec_t t[6];
        t[0] = '{32'h41E00000, 32'h40700000, 1'b0, 32'h41FE0000, 1'b0, 1'b0};
        t[1] = '{32'h41700000, 32'h41120000, 1'b0, 32'h41C10000, 1'b0, 1'b0};
        t[2] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0}; // tie, even
        t[3] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0}; // tie, odd
        t[4] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0}; // above half
        t[5] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 1'b0, 1'b0}; // round carry
        for (int i = 0; i < 6; i++) begin
            apply(t[i].a, t[i].b, t[i].op);
            vectors++;
            if (s !== t[i].s || ov !== t[i].ov || un !== t[i].un) begin
                miscompares++;
                $display("FAIL add[%0d]: got s=%h ov=%b un=%b, expected s=%h ov=%b un=%b",
                         i, s, ov, un, t[i].s, t[i].ov, t[i].un);
            end
        end
    endtask

    task automatic test_sub();
        vec_t t[4];
        t[0] = '{32'h3F400000, 32'h41320000, 1'b1, 32'hC1260000, 1'b0, 1'b0};
        t[1] = '{32'hC10E0000, 32'hC1CA0000, 1'b1, 32'h41830000, 1'b0, 1'b0};
        t[2] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 1'b0, 1'b0}; // borrow renormalise
        t[3] = '{32'h41E00000, 32'h41E00000, 1'b1, 32'h00000000, 1'b0, 1'b0}; // x - x
        for (int i = 0; i < 4; i++) begin
            apply(t[i].a, t[i].b, t[i].op);
            vectors++;
            if (s !== t[i].s || ov !== t[i].ov || un !== t[i].un) begin
                miscompares++;
                $display("FAIL sub[%0d]: got s=%h ov=%b un=%b, expected s=%h ov=%b un=%b",
                         i, s, ov, un, t[i].s, t[i].ov, t[i].un);
            end
        end
    endtask

    task automatic test_special();
        vec_t t[7];
        t[0] = '{32'h7F800000, 32'h41320000, 1'b0, 32'h7F800000, 1'b1, 1'b0};
        t[1] = '{32'hC3A30000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b1, 1'b0};
        t[2] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0}; // NaN in
        t[3] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0}; // inf - inf
        t[4] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b1, 1'b0}; // 1 - inf
        t[5] = '{32'h00000000, 32'h41700000, 1'b1, 32'hC1700000, 1'b0, 1'b0}; // 0 - 15
        t[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0}; // -0 + -0
        for (int i = 0; i < 7; i++) begin
            apply(t[i].a, t[i].b, t[i].op);
            vectors++;
            if (s !== t[i].s || ov !== t[i].ov || un !== t[i].un) begin
                miscompares++;
                $display("FAIL special[%0d]: got s=%h ov=%b un=%b, expected s=%h ov=%b un=%b",
                         i, s, ov, un, t[i].s, t[i].ov, t[i].un);
            end
        end
    endtask

    task automatic test_range();
        vec_t t[3];
        t[0] = '{32'h7F060000, 32'h7F600000, 1'b0, 32'h7F800000, 1'b1, 1'b0};
        t[1] = '{32'hFF060000, 32'hFF600000, 1'b0, 32'hFF800000, 1'b1, 1'b0};
        t[2] = '{32'h00800002, 32'h00400001, 1'b1, 32'h00000000, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            apply(t[i].a, t[i].b, t[i].op);
            vectors++;
            if (s !== t[i].s || ov !== t[i].ov || un !== t[i].un) begin
                miscompares++;
                $display("FAIL range[%0d]: got s=%h ov=%b un=%b, expected s=%h ov=%b un=%b",
                         i, s, ov, un, t[i].s, t[i].ov, t[i].un);
            end
        end
    endtask

    task automatic test_random();
        real         ra, rb, rr;
        logic [31:0] fa, fb, fe;
        logic        op;
        int          d;
        for (int i = 0; i < 200; i++) begin
            ra = $random / 1000.0;
            rb = $random / 1000.0;
            fa = real_to_f32(ra);
            fb = real_to_f32(rb);
            op = (i >= 100);
            rr = op ? f32_to_real(fa) - f32_to_real(fb) : f32_to_real(fa) + f32_to_real(fb);
            fe = real_to_f32(rr);
            apply(fa, fb, op);
            d = int'({1'b0, s[30:0]}) - int'({1'b0, fe[30:0]});
            vectors++;
            if ($isunknown({s, ov, un}) || s[31] !== fe[31] || d > 1 || d < -1 ||
                ov !== 1'b0 || un !== 1'b0) begin
                miscompares++;
                $display("FAIL sweep[%0d] %h op=%b %h: got s=%h ov=%b un=%b, expected %h +-1 ulp flags 0",
                         i, fa, op, fb, s, ov, un, fe);
            end
        end
    endtask

    task automatic test_back_to_back();
`ifdef FPU_OUT_REG_EN
        in_a = 32'h41700000; in_b = 32'h41120000; add_sub = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (s !== 32'h41C10000) begin
            miscompares++;
            $display("FAIL b2b_first: got s=%h, expected 41c10000", s);
        end
        in_a = 32'h3F400000; in_b = 32'h41320000; add_sub = 1'b1;
        #2;
        vectors++;
        if (s !== 32'h41C10000) begin
            miscompares++;
            $display("FAIL b2b_latency: got s=%h, expected previous 41c10000", s);
        end
        @(posedge clk); #1;
        vectors++;
        if (s !== 32'hC1260000) begin
            miscompares++;
            $display("FAIL b2b_second: got s=%h, expected c1260000", s);
        end
        in_a = 32'h7F060000; in_b = 32'h7F600000; add_sub = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (s !== 32'd0 || ov !== 1'b0 || un !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_async_reset: got s=%h ov=%b un=%b, expected s=00000000 ov=0 un=0", s, ov, un);
        end
        @(posedge clk); #1;
        vectors++;
        if (s !== 32'd0 || ov !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_reset_held: got s=%h ov=%b, expected s=00000000 ov=0", s, ov);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (s !== 32'h7F800000 || ov !== 1'b1 || un !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_after_reset: got s=%h ov=%b un=%b, expected s=7f800000 ov=1 un=0", s, ov, un);
        end
`else
        vec_t t[3];
        t[0] = '{32'h41700000, 32'h41120000, 1'b0, 32'h41C10000, 1'b0, 1'b0};
        t[1] = '{32'h3F400000, 32'h41320000, 1'b1, 32'hC1260000, 1'b0, 1'b0};
        t[2] = '{32'h7F060000, 32'h7F600000, 1'b0, 32'h7F800000, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            apply(t[i].a, t[i].b, t[i].op);
            vectors++;
            if (s !== t[i].s || ov !== t[i].ov || un !== t[i].un) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got s=%h ov=%b un=%b, expected s=%h ov=%b un=%b",
                         i, s, ov, un, t[i].s, t[i].ov, t[i].un);
            end
        end
`endif
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        in_a = 32'd0;
        in_b = 32'd0;
        add_sub = 1'b0;
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_add();
        test_sub();
        test_special();
        test_range();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
